// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC responder: FSM state encoding, default
// result width and the saturating offset add used when the sample is captured.
package adc_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StConvert
    } adc_state_e;

    localparam int unsigned DataWDefault = 8;

    // Sample plus signed offset, clamped into [0, 2^width-1]. The 64-bit sum
    // cannot wrap for any legal width, so clamping on it matches a DATA_W+2
    // bit signed sum followed by the same clamp.
    function automatic int unsigned sat_add_off(input int unsigned code,
                                                input int          offset,
                                                input int unsigned width);
        longint sum;
        longint max_code;
        sum      = longint'(code) + longint'(offset);
        max_code = (longint'(1) << width) - longint'(1);
        if (sum < 0) begin
            return 0;
        end
        if (sum > max_code) begin
            return 32'(max_code);
        end
        return 32'(sum);
    endfunction

endpackage

// File: rtl/adc_responder_convst_edge.sv
// Falling-edge detector for the active-low conversion start, qualified by the
// number of consecutive high cycles seen before the edge.
module convst_edge #(
    parameter int unsigned ACQ_MIN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic convst_bar,
    output logic start_ok,
    output logic start_bad
);

    localparam logic [7:0] AcqMax = 8'(ACQ_MIN);

    logic       cs_q;
    logic [7:0] acq_cnt_q;
    logic [7:0] acq_cnt_d;
    logic       fall;

    assign fall = cs_q & ~convst_bar;

    always_comb begin
        acq_cnt_d = acq_cnt_q;
        if (!convst_bar) begin
            acq_cnt_d = 8'd0;
        end else if (acq_cnt_q < AcqMax) begin
            acq_cnt_d = acq_cnt_q + 8'd1;
        end
    end

    // The counter is compared before this cycle's update, so it reflects the
    // high time that preceded the edge.
    assign start_ok  = fall & (acq_cnt_q == AcqMax);
    assign start_bad = fall & (acq_cnt_q != AcqMax);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_q      <= 1'b0;
            acq_cnt_q <= AcqMax;
        end else begin
            cs_q      <= convst_bar;
            acq_cnt_q <= acq_cnt_d;
        end
    end

endmodule

// File: rtl/adc_responder.sv
// Track-and-hold ADC stand-in: samples vin_code on an accepted start edge and
// presents the offset-adjusted result CONV_CYCLES later with a one-cycle valid.
module adc_responder
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W      = DataWDefault,
    parameter int unsigned CONV_CYCLES = 20,
    parameter int unsigned ACQ_MIN     = 4,
    parameter int          OFFSET      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              convst_bar,
    input  logic [DATA_W-1:0] vin_code,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              data_valid,
    output logic              overrun
);

    localparam logic [7:0] ConvLoad = 8'(CONV_CYCLES - 1);

    adc_state_e        state_q, state_d;
    logic [7:0]        conv_cnt_q, conv_cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              start_ok;
    logic              start_bad;
    logic              ovr_set;
    logic [DATA_W-1:0] sample;

    convst_edge #(
        .ACQ_MIN (ACQ_MIN)
    ) u_convst_edge (
        .clk        (clk),
        .rst        (rst),
        .convst_bar (convst_bar),
        .start_ok   (start_ok),
        .start_bad  (start_bad)
    );

    assign sample = DATA_W'(sat_add_off(32'(vin_code), OFFSET, DATA_W));

    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        hold_d     = hold_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        ovr_set    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    hold_d     = sample;
                    conv_cnt_d = ConvLoad;
                    busy_d     = 1'b1;
                    state_d    = StConvert;
                end else if (start_bad) begin
                    ovr_set = 1'b1;
                end
            end
            StConvert: begin
                // Any edge while converting is dropped, including one in the
                // completion cycle.
                ovr_set = start_ok | start_bad;
                if (conv_cnt_q == 8'd0) begin
                    data_out_d = hold_q;
                    valid_d    = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = StIdle;
                end else begin
                    conv_cnt_d = conv_cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        overrun_d = ovr_set | (overrun_q & ~ovr_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            conv_cnt_q <= 8'd0;
            hold_q     <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            hold_q     <= hold_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign busy       = busy_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_responder.sv
// Bench for adc_responder: three instances (offset 0, +10, -10) share stimulus
// and are checked each cycle against a cycle-numbered conversion model.
module tb_adc_responder;

    localparam int CONV = 20;
    localparam int ACQ  = 4;
    localparam int N    = 3;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       convst_bar = 1'b0;
    logic       ovr_clr    = 1'b0;
    logic [7:0] vin_code   = 8'h00;

    logic [7:0] dout  [N];
    logic       busy  [N];
    logic       valid [N];
    logic       ovr   [N];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adc_responder #(.DATA_W(8), .CONV_CYCLES(CONV), .ACQ_MIN(ACQ), .OFFSET(0)) u_dut0 (
        .clk(clk), .rst(rst), .convst_bar(convst_bar), .vin_code(vin_code), .ovr_clr(ovr_clr),
        .data_out(dout[0]), .busy(busy[0]), .data_valid(valid[0]), .overrun(ovr[0])
    );
    adc_responder #(.DATA_W(8), .CONV_CYCLES(CONV), .ACQ_MIN(ACQ), .OFFSET(10)) u_dut_p (
        .clk(clk), .rst(rst), .convst_bar(convst_bar), .vin_code(vin_code), .ovr_clr(ovr_clr),
        .data_out(dout[1]), .busy(busy[1]), .data_valid(valid[1]), .overrun(ovr[1])
    );
    adc_responder #(.DATA_W(8), .CONV_CYCLES(CONV), .ACQ_MIN(ACQ), .OFFSET(-10)) u_dut_n (
        .clk(clk), .rst(rst), .convst_bar(convst_bar), .vin_code(vin_code), .ovr_clr(ovr_clr),
        .data_out(dout[2]), .busy(busy[2]), .data_valid(valid[2]), .overrun(ovr[2])
    );

    // Model: conversions tracked by absolute cycle number of completion.
    int m_cyc    = 0;
    bit m_prev   = 1'b0;
    int m_run    = ACQ;
    bit m_active [N];
    int m_done   [N];
    int m_held   [N];
    int m_out    [N];
    bit m_valid  [N];
    bit m_busy   [N];
    bit m_ovr    [N];

    function automatic int off_of(input int i);
        if (i == 1) return 10;
        if (i == 2) return -10;
        return 0;
    endfunction

    function automatic int sat_model(input int v, input int off);
        int s;
        s = v + off;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_prev = 1'b0;
        m_run  = ACQ;
        for (int i = 0; i < N; i++) begin
            m_active[i] = 1'b0;
            m_done[i]   = 0;
            m_held[i]   = 0;
            m_out[i]    = 0;
            m_valid[i]  = 1'b0;
            m_busy[i]   = 1'b0;
            m_ovr[i]    = 1'b0;
        end
    endtask

    task automatic model_step();
        bit fall;
        bit set;
        fall = m_prev && !convst_bar;
        for (int i = 0; i < N; i++) begin
            set        = 1'b0;
            m_valid[i] = 1'b0;
            if (m_active[i]) begin
                if (m_cyc == m_done[i]) begin
                    m_out[i]    = m_held[i];
                    m_valid[i]  = 1'b1;
                    m_active[i] = 1'b0;
                end
                if (fall) set = 1'b1;
            end else if (fall) begin
                if (m_run >= ACQ) begin
                    m_held[i]   = sat_model(int'(vin_code), off_of(i));
                    m_active[i] = 1'b1;
                    m_done[i]   = m_cyc + CONV;
                end else begin
                    set = 1'b1;
                end
            end
            m_busy[i] = m_active[i];
            if (set) m_ovr[i] = 1'b1;
            else if (ovr_clr) m_ovr[i] = 1'b0;
        end
        m_run  = convst_bar ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
        m_prev = convst_bar;
        m_cyc++;
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset();
        end else begin
            model_step();
            #1;
            for (int i = 0; i < N; i++) begin
                check($sformatf("data_out[%0d]", i), int'(dout[i]), m_out[i]);
                check($sformatf("busy[%0d]", i), int'(busy[i]), int'(m_busy[i]));
                check($sformatf("data_valid[%0d]", i), int'(valid[i]), int'(m_valid[i]));
                check($sformatf("overrun[%0d]", i), int'(ovr[i]), int'(m_ovr[i]));
            end
        end
    end

    task automatic step(input logic cs, input logic [7:0] v, input logic clr);
        @(negedge clk);
        convst_bar = cs;
        vin_code   = v;
        ovr_clr    = clr;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int busy_cnt;
    int valid_cnt;
    int valid_at;
    int vdata;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data_out", int'(dout[0]), 0);
        check("reset_overrun", int'(ovr[0]), 0);
        rst = 1'b1;
        repeat (4) step(1'b0, 8'h5A, 1'b0);
        check("no_busy_low_through_reset", int'(busy[0]), 0);

        // First conversion, mid-flight vin change and an ignored edge at E+5.
        repeat (10) step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h5A, 1'b0);
        busy_cnt  = 0;
        valid_cnt = 0;
        valid_at  = 0;
        vdata     = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (busy[0]) busy_cnt++;
            if (valid[0]) begin
                valid_cnt++;
                valid_at = k;
                vdata    = int'(dout[0]);
            end
            if (k == 3) vin_code = 8'h11;
            convst_bar = (k == 3 || k == 4);
        end
        check("busy_length", busy_cnt, 20);
        check("valid_count", valid_cnt, 1);
        check("valid_cycle", valid_at, 21);
        check("first_result", vdata, 'h5A);
        check("overrun_on_busy_edge", int'(ovr[0]), 1);
        step(1'b0, 8'h11, 1'b1);
        step(1'b0, 8'h11, 1'b0);
        check("overrun_cleared", int'(ovr[0]), 0);

        // Short acquisition rejected, full acquisition accepted.
        repeat (2) step(1'b1, 8'h22, 1'b0);
        step(1'b0, 8'h22, 1'b0);
        step(1'b0, 8'h22, 1'b0);
        check("short_acq_overrun", int'(ovr[0]), 1);
        check("short_acq_no_busy", int'(busy[0]), 0);
        repeat (4) step(1'b1, 8'h22, 1'b0);
        step(1'b0, 8'h22, 1'b0);
        step(1'b0, 8'h22, 1'b0);
        check("full_acq_busy", int'(busy[0]), 1);
        repeat (22) step(1'b0, 8'h22, 1'b0);
        check("full_acq_result", int'(dout[0]), 'h22);

        // Saturation at both ends.
        repeat (4) step(1'b1, 8'hFA, 1'b0);
        step(1'b0, 8'hFA, 1'b0);
        repeat (21) step(1'b0, 8'hFA, 1'b0);
        check("sat_high_pos_off", int'(dout[1]), 'hFF);
        check("sat_high_zero_off", int'(dout[0]), 'hFA);
        check("sat_high_neg_off", int'(dout[2]), 'hF0);
        repeat (4) step(1'b1, 8'h05, 1'b0);
        step(1'b0, 8'h05, 1'b0);
        repeat (21) step(1'b0, 8'h05, 1'b0);
        check("sat_low_neg_off", int'(dout[2]), 'h00);
        check("sat_low_pos_off", int'(dout[1]), 'h0F);

        // Reset at E+7 aborts the conversion.
        repeat (5) step(1'b1, 8'h33, 1'b0);
        step(1'b0, 8'h33, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", int'(busy[0]), 0);
        check("abort_data_out", int'(dout[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h77, 1'b0);
        repeat (22) step(1'b0, 8'h77, 1'b0);
        check("after_abort_result", int'(dout[0]), 'h77);

        // Randomised high/low runs, codes, clears and occasional resets.
        for (int it = 0; it < 200; it++) begin
            int hi_len;
            int lo_len;
            hi_len = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12) : $urandom_range(1, 6);
            lo_len = ($urandom_range(0, 2) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 8);
            for (int j = 0; j < hi_len; j++) begin
                step(1'b1, 8'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
            end
            for (int j = 0; j < lo_len; j++) begin
                step(1'b0, 8'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 24) == 0) reset_pulse();
        end

        repeat (3) step(1'b0, 8'h00, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
